ascon_sequencer: RTL and testbench
==================================

ASCON_SEQUENCER -- requirements
Module: ascon_sequencer

Interface
REQ-001 SHALL have parameter ROUND_MAX, default 12: highest permutation round count; round counter width 4 bits.
REQ-002 SHALL have ports clk_i (in, 1, clock) and rst_i (in, 1, reset), with one clock and a synchronous, active-high reset.
REQ-003 SHALL have port start_i (in, 1): request a new operation, sampled only in IDLE.
REQ-004 SHALL have port decrypt_enable_i (in, 1): operation mode, latched when start is accepted.
REQ-005 SHALL have ports nb_perm_a_i and nb_perm_b_i (in, 8 each): round counts a and b, latched when start is accepted.
REQ-006 SHALL have port ad_present_i (in, 1): associated data exists, latched when start is accepted.
REQ-007 SHALL have ports ad_valid_i, ad_last_i, data_valid_i and data_last_i (in, 1 each): block handshakes.
REQ-008 SHALL have ports ad_ready_o and data_ready_o (out, 1 each): block accept, a valid/ready pair.
REQ-009 SHALL have ports ad_xor_o and data_xor_o (out, 1 each): pulse to XOR the accepted block into the state.
REQ-010 SHALL have ports load_state_o, perm_en_o, xor_key_begin_o, xor_key_end_o and xor_dom_sep_o (out, 1 each): datapath strobes.
REQ-011 SHALL have port round_o (out, 4): round constant index.
REQ-012 SHALL have ports busy_o, data_out_valid_o, tag_valid_o and done_o (out, 1 each): status.
REQ-013 SHALL have port tag_match_i (in, 1) and port auth_fail_o (out, 1) only when ASCON_TAG_CHECK_EN is defined.

Function
REQ-014 SHALL implement the states IDLE, LOAD, INIT_PERM, INIT_KEY, AD_WAIT, AD_PERM, DOM_SEP, DATA_WAIT, DATA_PERM, FINAL_KEY, FINAL_PERM, FINAL_TAG, TAG_CHECK (macro builds only) and DONE.
REQ-015 SHALL, in IDLE with start_i=1, move to LOAD and latch decrypt_enable_i, the a/b counts and ad_present_i; start_i SHALL be ignored in every other state.
REQ-016 SHALL treat a latched count of 0 or greater than ROUND_MAX as ROUND_MAX.
REQ-017 SHALL assert load_state_o and busy_o for exactly 1 cycle in LOAD, then move to INIT_PERM.
REQ-018 SHALL, in each *_PERM state, assert perm_en_o for n cycles, where n is a for INIT_PERM and FINAL_PERM and b for AD_PERM and DATA_PERM.
REQ-019 SHALL drive round_o = ROUND_MAX-n+k on cycle k (k=0..n-1) of each *_PERM state, and round_o=0 outside *_PERM states.
REQ-020 SHALL, in INIT_KEY (1 cycle, xor_key_end_o=1), move to AD_WAIT if ad_present is latched, else to DOM_SEP.
REQ-021 SHALL, in AD_WAIT, hold ad_ready_o=1; on ad_valid_i&ad_ready_o it SHALL pulse ad_xor_o in that cycle, latch ad_last_i and move to AD_PERM.
REQ-022 SHALL, on AD_PERM exit, move to DOM_SEP if the latched ad_last is set, else to AD_WAIT.
REQ-023 SHALL, in DOM_SEP (1 cycle, xor_dom_sep_o=1), move to DATA_WAIT.
REQ-024 SHALL, in DATA_WAIT, hold data_ready_o=1; on acceptance it SHALL pulse data_xor_o, assert data_out_valid_o for 1 cycle on the next cycle, and move to FINAL_KEY if data_last_i=1, else to DATA_PERM.
REQ-025 SHALL return from DATA_PERM to DATA_WAIT.
REQ-026 SHALL pulse xor_key_begin_o in FINAL_KEY, then run FINAL_PERM.
REQ-027 SHALL pulse xor_key_end_o and tag_valid_o in FINAL_TAG.
REQ-028 SHALL assert done_o for 1 cycle in DONE, then return to IDLE.
REQ-029 SHALL hold busy_o=1 in all states except IDLE.
REQ-030 SHALL ignore a valid that is not paired with ready, and SHALL never assert both ready outputs in the same cycle.

Reset
REQ-031 SHALL, when rst_i=1 at a clock edge, go to IDLE and drive every output to 0, including auth_fail_o, and clear the counter and latches.
REQ-032 SHALL give rst_i priority over start_i and over any operation in progress.

Configuration
REQ-033 SHALL, with ASCON_TAG_CHECK_EN defined and decrypt latched, go FINAL_TAG -> TAG_CHECK (1 cycle) -> DONE; in TAG_CHECK it SHALL set auth_fail_o = ~tag_match_i, held until the next accepted start or reset.
REQ-034 SHALL, with ASCON_TAG_CHECK_EN defined and encrypt latched, go FINAL_TAG -> DONE.
REQ-035 SHALL, without ASCON_TAG_CHECK_EN, omit the TAG_CHECK state and the tag_match_i/auth_fail_o ports and always go FINAL_TAG -> DONE.

Verification
REQ-036 SHALL cover: encrypt, a=12, b=6, ad_present=0, one data block with last=1, data_valid high from start -> start at cycle 0, LOAD at 1, round_o 0..11 over cycles 2-13, DOM_SEP at 15, accept at 16, FINAL_PERM 18-29, tag_valid_o at 30, done_o at 31.
REQ-037 SHALL cover: two AD blocks with b=6 -> two AD_PERM runs with round_o 6..11, xor_dom_sep_o exactly once after the second run.
REQ-038 SHALL cover: a=0, b=13 -> both counts treated as 12 (round_o begins at 0 in every perm phase).
REQ-039 SHALL cover: rst_i=1 during FINAL_PERM -> next cycle in IDLE with all outputs 0; a start 1 cycle later runs normally.
REQ-040 SHALL cover: macro on, decrypt, tag_match_i=0 -> auth_fail_o=1 from TAG_CHECK, done_o one cycle later than encrypt; tag_match_i=1 -> auth_fail_o=0.
REQ-041 SHALL cover: start_i pulsed during DATA_WAIT -> no effect on state or latched parameters.

Source files
------------

// File: rtl/ascon_sequencer.sv
// Ascon AEAD control sequencer: drives permutation rounds, key/domain XORs and block handshakes.
// Optional tag check state and auth_fail_o output are built when ASCON_TAG_CHECK_EN is defined.
module ascon_sequencer #(
    parameter int unsigned ROUND_MAX = 12
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       decrypt_enable_i,
    input  logic [7:0] nb_perm_a_i,
    input  logic [7:0] nb_perm_b_i,
    input  logic       ad_present_i,
    input  logic       ad_valid_i,
    input  logic       ad_last_i,
    input  logic       data_valid_i,
    input  logic       data_last_i,
    output logic       ad_ready_o,
    output logic       data_ready_o,
    output logic       ad_xor_o,
    output logic       data_xor_o,
    output logic       load_state_o,
    output logic       perm_en_o,
    output logic       xor_key_begin_o,
    output logic       xor_key_end_o,
    output logic       xor_dom_sep_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       data_out_valid_o,
    output logic       tag_valid_o,
`ifdef ASCON_TAG_CHECK_EN
    input  logic       tag_match_i,
    output logic       auth_fail_o,
`endif
    output logic       done_o
);

    localparam logic [3:0] RMAX = 4'(ROUND_MAX);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        INIT_PERM,
        INIT_KEY,
        AD_WAIT,
        AD_PERM,
        DOM_SEP,
        DATA_WAIT,
        DATA_PERM,
        FINAL_KEY,
        FINAL_PERM,
        FINAL_TAG,
`ifdef ASCON_TAG_CHECK_EN
        TAG_CHECK,
`endif
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] perm_a_q, perm_b_q;
    logic       decrypt_q;
    logic       ad_present_q;
    logic       ad_last_q;
    logic       dout_valid_q;

    logic       start_ok;
    logic       ad_acc;
    logic       data_acc;
    logic       in_perm;
    logic [3:0] perm_n;
    logic       perm_last;

    // Zero or out-of-range requests fall back to the full round count.
    function automatic logic [3:0] clamp_rounds(input logic [7:0] n);
        clamp_rounds = (n == 8'd0 || n > 8'(ROUND_MAX)) ? RMAX : n[3:0];
    endfunction

    assign start_ok = (state_q == IDLE) && start_i;
    assign ad_acc   = (state_q == AD_WAIT) && ad_valid_i;
    assign data_acc = (state_q == DATA_WAIT) && data_valid_i;

    assign in_perm = (state_q == INIT_PERM) || (state_q == AD_PERM)
                  || (state_q == DATA_PERM) || (state_q == FINAL_PERM);

    assign perm_n = ((state_q == INIT_PERM) || (state_q == FINAL_PERM))
                  ? perm_a_q : perm_b_q;

    assign perm_last = (cnt_q == perm_n - 4'd1);

    // Rounds are right-aligned so the last round always uses constant ROUND_MAX-1.
    assign round_o = in_perm ? (RMAX - perm_n + cnt_q) : 4'd0;

    assign data_out_valid_o = dout_valid_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = 4'd0;
        ad_ready_o      = 1'b0;
        data_ready_o    = 1'b0;
        ad_xor_o        = 1'b0;
        data_xor_o      = 1'b0;
        load_state_o    = 1'b0;
        perm_en_o       = 1'b0;
        xor_key_begin_o = 1'b0;
        xor_key_end_o   = 1'b0;
        xor_dom_sep_o   = 1'b0;
        tag_valid_o     = 1'b0;
        done_o          = 1'b0;
        busy_o          = (state_q != IDLE);

        if (in_perm) begin
            perm_en_o = 1'b1;
            cnt_d     = perm_last ? 4'd0 : cnt_q + 4'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = LOAD;
            end
            LOAD: begin
                load_state_o = 1'b1;
                state_d      = INIT_PERM;
            end
            INIT_PERM: begin
                if (perm_last) state_d = INIT_KEY;
            end
            INIT_KEY: begin
                xor_key_end_o = 1'b1;
                state_d       = ad_present_q ? AD_WAIT : DOM_SEP;
            end
            AD_WAIT: begin
                ad_ready_o = 1'b1;
                if (ad_valid_i) begin
                    ad_xor_o = 1'b1;
                    state_d  = AD_PERM;
                end
            end
            AD_PERM: begin
                if (perm_last) state_d = ad_last_q ? DOM_SEP : AD_WAIT;
            end
            DOM_SEP: begin
                xor_dom_sep_o = 1'b1;
                state_d       = DATA_WAIT;
            end
            DATA_WAIT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    data_xor_o = 1'b1;
                    state_d    = data_last_i ? FINAL_KEY : DATA_PERM;
                end
            end
            DATA_PERM: begin
                if (perm_last) state_d = DATA_WAIT;
            end
            FINAL_KEY: begin
                xor_key_begin_o = 1'b1;
                state_d         = FINAL_PERM;
            end
            FINAL_PERM: begin
                if (perm_last) state_d = FINAL_TAG;
            end
            FINAL_TAG: begin
                xor_key_end_o = 1'b1;
                tag_valid_o   = 1'b1;
`ifdef ASCON_TAG_CHECK_EN
                state_d = decrypt_q ? TAG_CHECK : DONE;
`else
                state_d = DONE;
`endif
            end
`ifdef ASCON_TAG_CHECK_EN
            TAG_CHECK: begin
                state_d = DONE;
            end
`endif
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            perm_a_q     <= 4'd0;
            perm_b_q     <= 4'd0;
            decrypt_q    <= 1'b0;
            ad_present_q <= 1'b0;
            ad_last_q    <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_valid_q <= data_acc;
            if (start_ok) begin
                decrypt_q    <= decrypt_enable_i;
                perm_a_q     <= clamp_rounds(nb_perm_a_i);
                perm_b_q     <= clamp_rounds(nb_perm_b_i);
                ad_present_q <= ad_present_i;
            end
            if (ad_acc) ad_last_q <= ad_last_i;
        end
    end

`ifdef ASCON_TAG_CHECK_EN
    logic auth_q;

    // Verdict is visible combinationally during the check, then held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            auth_q <= 1'b0;
        end else if (start_ok) begin
            auth_q <= 1'b0;
        end else if (state_q == TAG_CHECK) begin
            auth_q <= ~tag_match_i;
        end
    end

    assign auth_fail_o = (state_q == TAG_CHECK) ? ~tag_match_i : auth_q;
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt_q;
`endif

endmodule

// File: tb/tb_ascon_sequencer.sv
// Testbench for ascon_sequencer: random operations expanded into per-cycle expected outputs.
// Builds with or without ASCON_TAG_CHECK_EN.
module tb_ascon_sequencer;

    localparam int RM = 12;

    typedef struct packed {
        logic       ad_ready;
        logic       data_ready;
        logic       ad_xor;
        logic       data_xor;
        logic       load;
        logic       perm;
        logic       kb;
        logic       ke;
        logic       ds;
        logic [3:0] rnd;
        logic       busy;
        logic       dov;
        logic       tag;
        logic       done;
        logic       auth;
    } outv_t;

    typedef struct packed {
        logic       start;
        logic       dec;
        logic [7:0] na;
        logic [7:0] nb;
        logic       adp;
        logic       adv;
        logic       adl;
        logic       dv;
        logic       dl;
        logic       match;
        logic       fperm;
        outv_t      exp;
    } step_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       decrypt_enable_i;
    logic [7:0] nb_perm_a_i;
    logic [7:0] nb_perm_b_i;
    logic       ad_present_i;
    logic       ad_valid_i;
    logic       ad_last_i;
    logic       data_valid_i;
    logic       data_last_i;
    logic       ad_ready_o;
    logic       data_ready_o;
    logic       ad_xor_o;
    logic       data_xor_o;
    logic       load_state_o;
    logic       perm_en_o;
    logic       xor_key_begin_o;
    logic       xor_key_end_o;
    logic       xor_dom_sep_o;
    logic [3:0] round_o;
    logic       busy_o;
    logic       data_out_valid_o;
    logic       tag_valid_o;
    logic       done_o;
    logic       tag_match_i;
    logic       auth_fail_o;

    int    total = 0;
    int    bad = 0;
    int    cur_op = 0;
    int    max_stall = 2;
    logic  auth_m = 1'b0;
    logic  pend_dov = 1'b0;
    step_t q[$];

    always #5 clk_i = ~clk_i;

    ascon_sequencer #(.ROUND_MAX(RM)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .decrypt_enable_i (decrypt_enable_i),
        .nb_perm_a_i      (nb_perm_a_i),
        .nb_perm_b_i      (nb_perm_b_i),
        .ad_present_i     (ad_present_i),
        .ad_valid_i       (ad_valid_i),
        .ad_last_i        (ad_last_i),
        .data_valid_i     (data_valid_i),
        .data_last_i      (data_last_i),
        .ad_ready_o       (ad_ready_o),
        .data_ready_o     (data_ready_o),
        .ad_xor_o         (ad_xor_o),
        .data_xor_o       (data_xor_o),
        .load_state_o     (load_state_o),
        .perm_en_o        (perm_en_o),
        .xor_key_begin_o  (xor_key_begin_o),
        .xor_key_end_o    (xor_key_end_o),
        .xor_dom_sep_o    (xor_dom_sep_o),
        .round_o          (round_o),
        .busy_o           (busy_o),
        .data_out_valid_o (data_out_valid_o),
        .tag_valid_o      (tag_valid_o),
`ifdef ASCON_TAG_CHECK_EN
        .tag_match_i      (tag_match_i),
        .auth_fail_o      (auth_fail_o),
`endif
        .done_o           (done_o)
    );

`ifndef ASCON_TAG_CHECK_EN
    assign auth_fail_o = 1'b0;
`endif

    function automatic logic [3:0] eff(input logic [7:0] n);
        return (n == 8'd0 || n > 8'(RM)) ? 4'(RM) : n[3:0];
    endfunction

    // Random background for every input; fields that matter are overridden.
    function automatic step_t junk(input logic busy);
        step_t s;
        s.start = busy ? ($urandom_range(0, 3) == 0) : 1'b0;
        s.dec   = 1'($urandom);
        s.na    = 8'($urandom);
        s.nb    = 8'($urandom);
        s.adp   = 1'($urandom);
        s.adv   = 1'($urandom);
        s.adl   = 1'($urandom);
        s.dv    = 1'($urandom);
        s.dl    = 1'($urandom);
        s.match = 1'($urandom);
        s.fperm = 1'b0;
        s.exp      = '0;
        s.exp.busy = busy;
        return s;
    endfunction

    task automatic push(input step_t s);
        s.exp.dov  = pend_dov;
        s.exp.auth = auth_m;
        pend_dov   = 1'b0;
        q.push_back(s);
    endtask

    task automatic perm(input int n, input logic fin);
        step_t s;
        for (int k = 0; k < n; k++) begin
            s = junk(1'b1);
            s.exp.perm = 1'b1;
            s.exp.rnd  = 4'(RM - n + k);
            s.fperm    = fin;
            push(s);
        end
    endtask

    task automatic build_op(input int gap, input logic dec,
                            input logic [7:0] na, input logic [7:0] nb,
                            input int nad, input int ndat,
                            input logic match);
        step_t s;
        int    ea;
        int    eb;
        ea = int'(eff(na));
        eb = int'(eff(nb));
        for (int g = 0; g < gap; g++) push(junk(1'b0));
        s = junk(1'b0);
        s.start = 1'b1;
        s.dec   = dec;
        s.na    = na;
        s.nb    = nb;
        s.adp   = (nad > 0);
        push(s);
        auth_m = 1'b0;
        s = junk(1'b1); s.exp.load = 1'b1; push(s);
        perm(ea, 1'b0);
        s = junk(1'b1); s.exp.ke = 1'b1; push(s);
        for (int i = 0; i < nad; i++) begin
            for (int w = $urandom_range(0, max_stall); w > 0; w--) begin
                s = junk(1'b1); s.adv = 1'b0; s.exp.ad_ready = 1'b1; push(s);
            end
            s = junk(1'b1);
            s.adv = 1'b1;
            s.adl = (i == nad - 1);
            s.exp.ad_ready = 1'b1;
            s.exp.ad_xor   = 1'b1;
            push(s);
            perm(eb, 1'b0);
        end
        s = junk(1'b1); s.exp.ds = 1'b1; push(s);
        for (int j = 0; j < ndat; j++) begin
            for (int w = $urandom_range(0, max_stall); w > 0; w--) begin
                s = junk(1'b1); s.dv = 1'b0; s.exp.data_ready = 1'b1; push(s);
            end
            s = junk(1'b1);
            s.dv = 1'b1;
            s.dl = (j == ndat - 1);
            s.exp.data_ready = 1'b1;
            s.exp.data_xor   = 1'b1;
            push(s);
            pend_dov = 1'b1;
            if (j != ndat - 1) perm(eb, 1'b0);
        end
        s = junk(1'b1); s.exp.kb = 1'b1; push(s);
        perm(ea, 1'b1);
        s = junk(1'b1); s.exp.ke = 1'b1; s.exp.tag = 1'b1; push(s);
`ifdef ASCON_TAG_CHECK_EN
        if (dec) begin
            auth_m = ~match;
            s = junk(1'b1); s.match = match; push(s);
        end
`endif
        s = junk(1'b1); s.exp.done = 1'b1; push(s);
    endtask

    function automatic outv_t sample();
        outv_t o;
        o.ad_ready   = ad_ready_o;
        o.data_ready = data_ready_o;
        o.ad_xor     = ad_xor_o;
        o.data_xor   = data_xor_o;
        o.load       = load_state_o;
        o.perm       = perm_en_o;
        o.kb         = xor_key_begin_o;
        o.ke         = xor_key_end_o;
        o.ds         = xor_dom_sep_o;
        o.rnd        = round_o;
        o.busy       = busy_o;
        o.dov        = data_out_valid_o;
        o.tag        = tag_valid_o;
        o.done       = done_o;
        o.auth       = auth_fail_o;
        return o;
    endfunction

    task automatic check(input string tag, input int idx,
                         input outv_t got, input outv_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s op%0d step%0d got=%h exp=%h",
                   tag, cur_op, idx, got, exp);
        end
    endtask

    task automatic drive(input step_t s);
        start_i          = s.start;
        decrypt_enable_i = s.dec;
        nb_perm_a_i      = s.na;
        nb_perm_b_i      = s.nb;
        ad_present_i     = s.adp;
        ad_valid_i       = s.adv;
        ad_last_i        = s.adl;
        data_valid_i     = s.dv;
        data_last_i      = s.dl;
        tag_match_i      = s.match;
    endtask

    task automatic play(input int rst_at);
        step_t s;
        for (int i = 0; i < q.size(); i++) begin
            s = q[i];
            drive(s);
            rst_i = (i == rst_at);
            @(negedge clk_i);
            check("step", i, sample(), s.exp);
            @(posedge clk_i);
            #1;
            if (i == rst_at) begin
                rst_i = 1'b0;
                drive(junk(1'b0));
                @(negedge clk_i);
                check("post_rst", i, sample(), outv_t'(0));
                @(posedge clk_i);
                #1;
                auth_m   = 1'b0;
                pend_dov = 1'b0;
                break;
            end
        end
        q.delete();
        cur_op++;
    endtask

    function automatic int first_fperm();
        for (int i = 0; i < q.size(); i++)
            if (q[i].fperm) return i;
        return -1;
    endfunction

    initial begin
        int at;
        rst_i = 1'b1;
        drive(junk(1'b0));
        start_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i);
            #1;
            @(negedge clk_i);
            check("reset", 0, sample(), outv_t'(0));
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        max_stall = 0;
        build_op(0, 1'b0, 8'd12, 8'd6, 0, 1, 1'b1);
        play(-1);

        max_stall = 2;
        build_op(1, 1'b0, 8'd12, 8'd6, 2, 2, 1'b1);
        play(-1);

        build_op(1, 1'b0, 8'd0, 8'd13, 1, 2, 1'b1);
        play(-1);

        build_op(1, 1'b0, 8'd8, 8'd4, 1, 1, 1'b1);
        at = first_fperm() + $urandom_range(0, 7);
        play(at);

        build_op(0, 1'b0, 8'd12, 8'd6, 0, 1, 1'b1);
        play(-1);

        build_op(1, 1'b1, 8'd12, 8'd6, 1, 1, 1'b0);
        play(-1);
        build_op(1, 1'b1, 8'd12, 8'd6, 1, 1, 1'b1);
        play(-1);
        build_op(1, 1'b0, 8'd12, 8'd6, 0, 1, 1'b0);
        play(-1);

        for (int r = 0; r < 25; r++) begin
            build_op($urandom_range(0, 2), 1'($urandom),
                     8'($urandom_range(0, 20)), 8'($urandom_range(0, 20)),
                     $urandom_range(0, 3), $urandom_range(1, 3),
                     1'($urandom));
            play(-1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
